// File: rtl/qspi_fetch_arbiter.sv
// qspi_fetch_arbiter
// Shares the QSPI word-list fetch port between the game logic (requester 0)
// and a secondary reader (requester 1). Round-robin arbitration on ties,
// a one-entry result cache in front of the flash, and a fetch timeout so a
// lost fetch_done turns into an error response instead of a hung game.
module qspi_fetch_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req1,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic              rsp0_err,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              cache_flush,
    output logic              fetch,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic [DATA_W-1:0] fetch_result,
    input  logic              fetch_done
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    // Count value seen in the last permitted FETCH cycle; fetch stays high
    // for exactly TIMEOUT cycles before the error response.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state;
    logic               grant;
    logic               last_grant;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               cache_valid;
    logic               flush_seen;
    logic               fill_pend;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  cache_addr;
    logic [DATA_W-1:0]  cache_data;

    logic               sel_valid;
    logic               sel_id;
    logic [ADDR_W-1:0]  sel_addr;
    logic               hit;
    logic               fill_now;

    // Arbitration, cache lookup and fill qualification for the current cycle.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = 1'b0;
        if (req0 && req1) begin
            sel_valid = 1'b1;
            sel_id    = ~last_grant;
        end else if (req0) begin
            sel_valid = 1'b1;
            sel_id    = 1'b0;
        end else if (req1) begin
            sel_valid = 1'b1;
            sel_id    = 1'b1;
        end
        sel_addr = sel_id ? req1_addr : req0_addr;
        // A flush in the lookup cycle already invalidates the entry.
        hit      = cache_valid && !cache_flush && (sel_addr == cache_addr);
        // A flush in the fill cycle wins over the fill.
        fill_now = (state == RESP) && fill_pend && !cache_flush;
    end

    // Control FSM with registered outputs to requesters and the QSPI controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            tmo_cnt     <= '0;
            cache_valid <= 1'b0;
            flush_seen  <= 1'b0;
            fill_pend   <= 1'b0;
            fetch       <= 1'b0;
            fetch_addr  <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_err    <= 1'b0;
            rsp1_err    <= 1'b0;
            rsp_data    <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp1_err   <= 1'b0;
            if (cache_flush) begin
                cache_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant      <= sel_id;
                        last_grant <= sel_id;
                        if (hit) begin
                            state      <= RESP;
                            rsp_data   <= cache_data;
                            fill_pend  <= 1'b0;
                            rsp0_valid <= ~sel_id;
                            rsp1_valid <= sel_id;
                        end else begin
                            state      <= FETCH;
                            fetch      <= 1'b1;
                            fetch_addr <= sel_addr;
                            tmo_cnt    <= '0;
                            flush_seen <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (cache_flush) begin
                        flush_seen <= 1'b1;
                    end
                    // A completion in the timeout cycle still counts as success.
                    if (fetch_done) begin
                        state      <= RESP;
                        fetch      <= 1'b0;
                        rsp_data   <= fetch_result;
                        fill_pend  <= !flush_seen && !cache_flush;
                        rsp0_valid <= ~grant;
                        rsp1_valid <= grant;
                    end else if (tmo_cnt == CNT_LAST) begin
                        state      <= RESP;
                        fetch      <= 1'b0;
                        rsp_data   <= '0;
                        fill_pend  <= 1'b0;
                        rsp0_valid <= ~grant;
                        rsp1_valid <= grant;
                        rsp0_err   <= ~grant;
                        rsp1_err   <= grant;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    fill_pend <= 1'b0;
                    if (fill_now) begin
                        cache_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Captured request address and cache payload; meaningful only when qualified.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && sel_valid) begin
            addr_q <= sel_addr;
        end
        if (fill_now) begin
            cache_addr <= addr_q;
            cache_data <= rsp_data;
        end
    end

endmodule

// File: tb/tb_qspi_fetch_arbiter.sv
// Scoreboard bench for qspi_fetch_arbiter: directed requests push expected
// responses and fetch addresses into queues; a monitor and a QSPI model
// pop and compare as the DUT produces them.
module tb_qspi_fetch_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    logic              clk;
    logic              rst_n;
    logic              req0;
    logic [ADDR_W-1:0] req0_addr;
    logic              req1;
    logic [ADDR_W-1:0] req1_addr;
    logic              rsp0_valid;
    logic              rsp1_valid;
    logic              rsp0_err;
    logic              rsp1_err;
    logic [DATA_W-1:0] rsp_data;
    logic              cache_flush;
    logic              fetch;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_result;
    logic              fetch_done;

    typedef struct packed {
        logic              id;
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    logic [ADDR_W-1:0] fq[$];

    int errors = 0;
    int checks = 0;

    // QSPI model configuration (written by the stimulus process only)
    int                qspi_delay = 0;      // 0 = never complete
    logic [DATA_W-1:0] qspi_data  = '0;
    bit                flush_in_fetch = 0;
    // QSPI model status (written by the model process only)
    int                fetch_starts = 0;
    int                last_len = 0;

    qspi_fetch_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .req0_addr   (req0_addr),
        .req1        (req1),
        .req1_addr   (req1_addr),
        .rsp0_valid  (rsp0_valid),
        .rsp1_valid  (rsp1_valid),
        .rsp0_err    (rsp0_err),
        .rsp1_err    (rsp1_err),
        .rsp_data    (rsp_data),
        .cache_flush (cache_flush),
        .fetch       (fetch),
        .fetch_addr  (fetch_addr),
        .fetch_result(fetch_result),
        .fetch_done  (fetch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: every response must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp_data},
                        {~e.id, e.id, e.err & ~e.id, e.err & e.id, e.data});
                end
            end
        end
    end

    // QSPI controller model: checks fetch addresses, answers after qspi_delay
    // cycles, optionally flushes in the second fetch cycle.
    initial begin
        bit active;
        bit done_seen;
        int flen;
        active = 0;
        done_seen = 0;
        flen = 0;
        fetch_done = 1'b0;
        fetch_result = '0;
        cache_flush = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fetch_done = 1'b0;
            cache_flush = 1'b0;
            fetch_result = ~qspi_data;
            if (fetch) begin
                if (!active) begin
                    active = 1;
                    flen = 0;
                    fetch_starts++;
                    if (fq.size() == 0) chk("unexpected_fetch", fetch, 1'b0);
                    else chk("fetch_addr", fetch_addr, fq.pop_front());
                end
                flen++;
                if (qspi_delay != 0 && flen == qspi_delay + 1) begin
                    fetch_done = 1'b1;
                    fetch_result = qspi_data;
                    done_seen = 1;
                end
                if (flush_in_fetch && flen == 2) cache_flush = 1'b1;
            end else if (active) begin
                active = 0;
                last_len = flen;
                if (done_seen) chk("rsp_after_done", {rsp0_valid | rsp1_valid, fetch}, 2'b10);
                done_seen = 0;
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_fetch"}, fetch, 1'b0);
        chk({tag, "_fetch_addr"}, fetch_addr, '0);
        chk({tag, "_rsp_valid"}, {rsp0_valid, rsp1_valid}, 2'b00);
        chk({tag, "_rsp_err"}, {rsp0_err, rsp1_err}, 2'b00);
        chk({tag, "_rsp_data"}, rsp_data, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
    endtask

    // One request; exp_lat = negedges from request drive to response (0 = skip),
    // exp_len = fetch-high cycles of this transaction (0 = skip).
    task automatic run_req(input int id, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data, input logic err,
                           input int dly, input int nfetch, input int exp_lat,
                           input int exp_len);
        exp_t e;
        int   f0;
        int   w;
        bit   got;
        e.id = id[0];
        e.err = err;
        e.data = data;
        exp_q.push_back(e);
        if (nfetch != 0) fq.push_back(addr);
        qspi_delay = dly;
        qspi_data = data;
        f0 = fetch_starts;
        @(posedge clk);
        #1;
        if (id == 0) begin
            req0 = 1'b1;
            req0_addr = addr;
        end else begin
            req1 = 1'b1;
            req1_addr = addr;
        end
        got = 0;
        w = 0;
        while (!got && w < 40) begin
            @(negedge clk);
            w++;
            got = (id == 0) ? rsp0_valid : rsp1_valid;
        end
        chk("rsp_seen", got, 1'b1);
        if (exp_lat != 0) chk("rsp_latency", w, exp_lat);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        chk("fetch_count", fetch_starts - f0, nfetch);
        if (exp_len != 0) chk("fetch_len", last_len, exp_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;
        int f0;
        exp_t e;
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        req0_addr = '0;
        req1_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("por");
        rst_n = 1'b1;

        // Miss: done 3 cycles after fetch rises, response one cycle after done
        run_req(0, 24'h000100, 32'hDEADBEEF, 1'b0, 3, 1, 6, 4);
        // Hit: no fetch, response in the cycle after sampling
        run_req(0, 24'h000100, 32'hDEADBEEF, 1'b0, 0, 0, 2, 0);

        // Simultaneous requests from reset: 0,1,0,1
        do_reset();
        qspi_delay = 2;
        qspi_data = 32'h55AA1234;
        for (int i = 0; i < 4; i++) begin
            e.id = i[0];
            e.err = 1'b0;
            e.data = 32'h55AA1234;
            exp_q.push_back(e);
            fq.push_back(i[0] ? 24'h000300 : 24'h000200);
        end
        f0 = fetch_starts;
        @(posedge clk);
        #1;
        req0 = 1'b1;
        req0_addr = 24'h000200;
        req1 = 1'b1;
        req1_addr = 24'h000300;
        n = 0;
        w = 0;
        while (n < 4 && w < 100) begin
            @(negedge clk);
            w++;
            n += int'(rsp0_valid) + int'(rsp1_valid);
        end
        chk("alt_rsp_count", n, 4);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        chk("alt_fetch_count", fetch_starts - f0, 4);

        // Timeout: fetch high TMO cycles, error response, no fill
        run_req(1, 24'h000400, 32'h0, 1'b1, 0, 1, 10, TMO);
        run_req(1, 24'h000400, 32'h12345678, 1'b0, 2, 1, 5, 0);

        // Flush during FETCH suppresses the fill
        flush_in_fetch = 1;
        run_req(0, 24'h000500, 32'hCAFEF00D, 1'b0, 4, 1, 7, 0);
        flush_in_fetch = 0;
        run_req(0, 24'h000500, 32'hCAFEF00D, 1'b0, 2, 1, 5, 0);
        run_req(0, 24'h000500, 32'hCAFEF00D, 1'b0, 0, 0, 2, 0);

        // Done coincident with timeout: success, and the entry is cached
        run_req(1, 24'h000600, 32'h0BADCAFE, 1'b0, 7, 1, 10, TMO);
        run_req(1, 24'h000600, 32'h0BADCAFE, 1'b0, 0, 0, 2, 0);

        // Reset mid-FETCH: fetch drops at once, no response, cache invalid
        fq.push_back(24'h000700);
        qspi_delay = 0;
        @(posedge clk);
        #1;
        req1 = 1'b1;
        req1_addr = 24'h000700;
        w = 0;
        while (!fetch && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("mid_fetch_started", fetch, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_fetch", fetch, 1'b0);
        chk("mid_reset_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("post_reset");
        run_req(1, 24'h000600, 32'h0BADCAFE, 1'b0, 3, 1, 6, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("fq_drained", fq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qspi_fetch_arbiter.md
# qspi_fetch_arbiter

Shares the single QSPI word-list fetch port between two requesters: requester 0 is the game logic (answer/word-list reads), and requester 1 is a secondary reader, such as a guess-validity checker. The block does round-robin arbitration, keeps a one-entry result cache, and applies a timeout so a lost `fetch_done` cannot stall the game. It sits between the requesters and the QSPI controller, and owns that controller's `fetch` / `fetch_addr` / `fetch_result` interface.

## Interface
- `ADDR_W`, 24, fetch address width
- `DATA_W`, 32, fetch result width
- `TIMEOUT`, 1023, maximum cycles in FETCH before an error response (counter width is `$clog2(TIMEOUT+1)`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req0`, `req1`  in  1 each  request level; held until the matching `rsp*_valid`
- `req0_addr`, `req1_addr`  in  ADDR_W each  request address; stable while the request is held
- `rsp0_valid`, `rsp1_valid`  out  1 each  one-cycle response pulse
- `rsp0_err`, `rsp1_err`  out  1 each  timeout flag; valid with `rsp*_valid`
- `rsp_data`  out  DATA_W  shared response data; valid with either `rsp*_valid`
- `cache_flush`  in  1  invalidate the cached entry (used on new game / word-list change)
- `fetch`  out  1  QSPI fetch request level
- `fetch_addr`  out  ADDR_W  QSPI address
- `fetch_result`  in  DATA_W  QSPI data; valid in the `fetch_done` cycle
- `fetch_done`  in  1  one-cycle completion pulse from the QSPI controller

## Operation
- States: IDLE, FETCH, RESP.
- **IDLE**
  - With no request, stay in IDLE.
  - With one request, select it.
  - With both requests, select the requester that is not `last_grant`.
  - On selection, register the grant id and address, and set `last_grant`.
  - Cache hit (`cache_valid` and address equal to `cache_addr`): go to RESP with the cached data.
  - Miss: go to FETCH.
- **FETCH**
  - `fetch` = 1 and `fetch_addr` = captured address, both registered.
  - The timeout counter increments each cycle.
  - `fetch_done`: capture `fetch_result` and go to RESP with err = 0.
  - Counter reaches TIMEOUT with no `fetch_done`: go to RESP with err = 1 and data = 0.
  - `fetch_done` in the same cycle as the timeout: done wins.
- **RESP**
  - Pulse `rsp<grant>_valid` for exactly one cycle; `rsp_data` and `rsp*_err` are valid.
  - `fetch` = 0.
  - The cache is filled (addr, data, valid = 1) only after a successful fetch.
  - Next state is IDLE.
- Cache flush
  - `cache_flush` clears `cache_valid` in any state.
  - Flush in the RESP fill cycle: flush wins, and the entry stays invalid.
  - A flush asserted at any time during FETCH also suppresses that transaction's fill.
  - Flush does not abort a transaction in flight.
- Protocol and error handling
  - `fetch_done` outside FETCH is ignored.
  - A requester dropping its `req` mid-transaction does not abort the transaction; the response still pulses.
  - After a `rsp*_valid` in cycle R, a request still asserted in cycle R+1 is a new request.
- Reset values: state IDLE, all outputs 0, `cache_valid` 0, timeout counter 0, `last_grant` = 1 (requester 0 wins the first tie).
- Asynchronous reset during FETCH drops `fetch` immediately, with no response.

## Timing
- Request sampled in IDLE in cycle N:
  - Hit: `rsp_valid` in cycle N+1; total latency 1.
  - Miss: `fetch` is high from N+1.
- Miss completion: `fetch_done` in cycle M gives `rsp_valid` in M+1, with `fetch` low in M+1.
- Timeout: `fetch` high for exactly TIMEOUT cycles, then the error response in the following cycle.
- The earliest next arbitration after RESP in cycle R is cycle R+1, so back-to-back hits sustain one response every 2 cycles.
- `fetch_addr` holds its value outside FETCH; only `fetch` qualifies it.

## Test plan
- **Reset, then `req0` miss.** Drive `req0`, addr 0x000100, with `fetch_done` 3 cycles after `fetch` rises and `fetch_result` 0xDEADBEEF.
  - Required: `fetch_addr` 0x000100; `rsp0_valid` one cycle after done; `rsp_data` 0xDEADBEEF; err 0.
- **Cache hit.** Repeat `req0` 0x000100.
  - Required: no `fetch` pulse; `rsp0_valid` one cycle after sampling; data 0xDEADBEEF.
- **Simultaneous requests from reset.** Assert `req0` and `req1` together.
  - Required: `req0` is served first.
  - Then, with `req0` re-asserted, `req1` is served next.
  - Then `req0` again (alternation across 4 transactions).
- **Timeout.** Set TIMEOUT 8 and never assert `fetch_done`.
  - Required: `fetch` high for 8 cycles, then `rsp1_valid` with `rsp1_err` 1, data 0.
  - Required: a repeat request to the same address causes a new fetch (no cache fill).
- **Flush race.** Assert `cache_flush` during FETCH, then re-request the same address.
  - Required: a new fetch occurs.
  - Also: `fetch_done` coincident with the timeout gives err 0.
- **Reset mid-FETCH.**
  - Required: `fetch` goes 0 immediately; no `rsp*_valid`; the cache is invalid afterwards.
